// File: rtl/voice_pkg.sv
// voice_pkg: constants and FSM state encoding shared by the voice scheduler
// and its phase bank.
package voice_pkg;

    localparam int NV_DEF = 4;   // voices sharing one ROM path
    localparam int PW_DEF = 21;  // phase accumulator width
    localparam int DW_DEF = 8;   // signed ROM sample width
    localparam int ADDR_W = 11;  // ROM raw address width, taken from the phase MSBs

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/phase_bank.sv
// phase_bank: per-voice phase accumulators and phase increments.
//   clk, rst          clock, async active-high reset
//   inc_wr/sel/data   increment write port, takes effect on the next edge
//   upd, upd_idx      advance (or zero) the phase of voice upd_idx this cycle
//   upd_en            1: phase += inc, 0: phase cleared
//   rd_idx, rd_addr   combinational read of the phase MSBs of voice rd_idx
module phase_bank
    import voice_pkg::*;
#(
    parameter int NV = NV_DEF,
    parameter int PW = PW_DEF,
    parameter int VW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_wr,
    input  logic [1:0]        inc_sel,
    input  logic [PW-1:0]     inc_data,
    input  logic              upd,
    input  logic [VW-1:0]     upd_idx,
    input  logic              upd_en,
    input  logic [VW-1:0]     rd_idx,
    output logic [ADDR_W-1:0] rd_addr
);

    logic [PW-1:0] phase_q [NV];
    logic [PW-1:0] phase_d [NV];
    logic [PW-1:0] inc_q   [NV];
    logic [PW-1:0] inc_d   [NV];

    // The phase adder reads inc_q, so a voice advanced in the same cycle as an
    // increment write still steps by the old increment.
    always_comb begin
        for (int i = 0; i < NV; i++) begin
            phase_d[i] = phase_q[i];
            inc_d[i]   = inc_q[i];
            if (inc_wr && inc_sel == 2'(i)) begin
                inc_d[i] = inc_data;
            end
            if (upd && upd_idx == VW'(i)) begin
                phase_d[i] = upd_en ? phase_q[i] + inc_q[i] : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NV; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NV; i++) begin
                phase_q[i] <= phase_d[i];
                inc_q[i]   <= inc_d[i];
            end
        end
    end

    assign rd_addr = phase_q[rd_idx][PW-1:PW-ADDR_W];

endmodule

// File: rtl/voice_sched.sv
// voice_sched: time-shares one sine ROM among NV voices and mixes them into
// one output sample per sample_tick.
//   clk, rst            clock, async active-high reset
//   sample_tick         request one mixed sample
//   voice_en            per-voice enable (disabled voice: phase zeroed, adds 0)
//   inc_wr/sel/data     phase increment write port
//   raw_addr, rom_en    registered ROM address and read enable
//   rom_data            synchronous ROM sample, one cycle after its address
//   mix, mix_valid      signed sum of enabled voices, one-cycle valid pulse
//   busy                FSM not idle
//   ovr, clr_ovr        sticky "tick while busy" flag and its clear
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for sample_tick, raw_addr holds
//   ST_RUN   | NV cycles, voice vidx address on the ROM, phase advanced
//   ST_DRAIN | last ROM sample accumulated, mix loaded
module voice_sched
    import voice_pkg::*;
#(
    parameter int NV = NV_DEF,
    parameter int PW = PW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic [NV-1:0]     voice_en,
    input  logic              inc_wr,
    input  logic [1:0]        inc_sel,
    input  logic [PW-1:0]     inc_data,
    output logic [ADDR_W-1:0] raw_addr,
    output logic              rom_en,
    input  logic [DW-1:0]     rom_data,
    output logic [DW+1:0]     mix,
    output logic              mix_valid,
    output logic              busy,
    output logic              ovr,
    input  logic              clr_ovr
);

    localparam int VW = (NV > 1) ? $clog2(NV) : 1;
    localparam int MW = DW + 2;

    logic [1:0]              state_q, state_d;
    logic [VW-1:0]           vidx_q, vidx_d;
    logic [ADDR_W-1:0]       raw_addr_q, raw_addr_d;
    logic                    rom_en_q, rom_en_d;
    logic                    take_q, take_d;
    logic signed [MW-1:0]    acc_q, acc_d;
    logic signed [MW-1:0]    mix_q, mix_d;
    logic                    mix_valid_q, mix_valid_d;
    logic                    ovr_q, ovr_d;

    logic [VW-1:0]           rd_idx;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    last;
    logic signed [MW-1:0]    contrib;
    logic signed [MW-1:0]    acc_sum;

    phase_bank #(.NV(NV), .PW(PW), .VW(VW)) u_phase_bank (
        .clk      (clk),
        .rst      (rst),
        .inc_wr   (inc_wr),
        .inc_sel  (inc_sel),
        .inc_data (inc_data),
        .upd      (state_q == ST_RUN),
        .upd_idx  (vidx_q),
        .upd_en   (voice_en[vidx_q]),
        .rd_idx   (rd_idx),
        .rd_addr  (rd_addr)
    );

    // raw_addr is registered, so the address loaded at an edge belongs to the
    // RUN cycle that edge starts: voice 0 from IDLE, voice vidx+1 from RUN.
    assign rd_idx  = (state_q == ST_RUN) ? vidx_q + VW'(1) : '0;
    assign last    = (vidx_q == VW'(NV - 1));
    // take_q marks that the sample now on rom_data came from an enabled voice.
    assign contrib = take_q ? MW'($signed(rom_data)) : '0;
    assign acc_sum = acc_q + contrib;

    always_comb begin
        state_d     = state_q;
        vidx_d      = vidx_q;
        raw_addr_d  = raw_addr_q;
        rom_en_d    = 1'b0;
        take_d      = 1'b0;
        acc_d       = acc_q;
        mix_d       = mix_q;
        mix_valid_d = 1'b0;
        ovr_d       = ovr_q & ~clr_ovr;

        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_d    = ST_RUN;
                    vidx_d     = '0;
                    acc_d      = '0;
                    raw_addr_d = rd_addr;
                    rom_en_d   = 1'b1;
                end
            end
            ST_RUN: begin
                take_d = voice_en[vidx_q];
                acc_d  = acc_sum;
                if (last) begin
                    state_d = ST_DRAIN;
                end else begin
                    vidx_d     = vidx_q + VW'(1);
                    raw_addr_d = rd_addr;
                    rom_en_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                acc_d       = acc_sum;
                mix_d       = acc_sum;
                mix_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Setting has priority over clr_ovr in the same cycle.
        if (sample_tick && state_q != ST_IDLE) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vidx_q      <= '0;
            raw_addr_q  <= '0;
            rom_en_q    <= 1'b0;
            take_q      <= 1'b0;
            acc_q       <= '0;
            mix_q       <= '0;
            mix_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            vidx_q      <= vidx_d;
            raw_addr_q  <= raw_addr_d;
            rom_en_q    <= rom_en_d;
            take_q      <= take_d;
            acc_q       <= acc_d;
            mix_q       <= mix_d;
            mix_valid_q <= mix_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign raw_addr  = raw_addr_q;
    assign rom_en    = rom_en_q;
    assign mix       = mix_q;
    assign mix_valid = mix_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_voice_sched.sv
module tb_voice_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_tick = 1'b0;
    logic [3:0]  voice_en = 4'b0000;
    logic        inc_wr = 1'b0;
    logic [1:0]  inc_sel = 2'd0;
    logic [20:0] inc_data = '0;
    logic [10:0] raw_addr;
    logic        rom_en;
    logic [7:0]  rom_data = 8'd0;
    logic [9:0]  mix;
    logic        mix_valid;
    logic        busy;
    logic        ovr;
    logic        clr_ovr = 1'b0;

    voice_sched dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .voice_en    (voice_en),
        .inc_wr      (inc_wr),
        .inc_sel     (inc_sel),
        .inc_data    (inc_data),
        .raw_addr    (raw_addr),
        .rom_en      (rom_en),
        .rom_data    (rom_data),
        .mix         (mix),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .ovr         (ovr),
        .clr_ovr     (clr_ovr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ROM model: constant value, or a value derived from the address.
    bit rom_addr_mode = 1'b0;
    int rom_k = 0;

    function automatic int rom_val(input logic [10:0] a);
        if (rom_addr_mode) return int'($signed(a[7:0]));
        return rom_k;
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_data <= 8'(rom_val(raw_addr));
    end

    // Reference model of the phase state.
    logic [20:0] m_ph  [4];
    logic [20:0] m_inc [4];

    typedef struct { int val; int due; } exp_t;
    exp_t mix_q[$];
    int   addr_q[$];

    // Scoreboard consumers.
    always @(negedge clk) begin
        if (!rst && rom_en) begin
            if (addr_q.size() == 0) chk("rom_en_unexpected", 1, 0);
            else chk("raw_addr", int'(raw_addr), addr_q.pop_front());
        end
        if (mix_valid) begin
            if (mix_q.size() == 0) chk("mix_valid_unexpected", 1, 0);
            else begin
                exp_t e;
                e = mix_q.pop_front();
                chk("mix", int'($signed(mix)), e.val);
                chk("mix_valid_cycle", cyc, e.due);
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_ph[k]  = '0;
            m_inc[k] = '0;
        end
    endtask

    task automatic write_inc(input int sel, input logic [20:0] d);
        inc_wr = 1'b1; inc_sel = 2'(sel); inc_data = d;
        @(negedge clk);
        inc_wr = 1'b0;
        m_inc[sel] = d;
    endtask

    // Issues an accepted tick (caller ensures idle). Expected addresses and
    // the expected mix are pushed here; returns in RUN cycle 0.
    task automatic tick_sample(input logic [3:0] en, input bit use_model, input int exp_mix);
        int   sum;
        exp_t e;
        sum = 0;
        voice_en = en;
        for (int k = 0; k < 4; k++) begin
            logic [10:0] a;
            a = m_ph[k][20:10];
            addr_q.push_back(int'(a));
            if (en[k]) begin
                sum += rom_val(a);
                m_ph[k] = m_ph[k] + m_inc[k];
            end else begin
                m_ph[k] = '0;
            end
        end
        e.val = use_model ? sum : exp_mix;
        e.due = cyc + 6;
        mix_q.push_back(e);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mix_q.size() == 0 && addr_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) chk("wait_idle_timeout", 0, 1);
    endtask

    typedef struct {
        logic [3:0] en;
        bit         addr_mode;
        int         k;
        bit         use_model;
        int         exp_mix;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'b1111, 1'b0, -128, 1'b0, -512};
        vecs[1] = '{4'b0101, 1'b0, -128, 1'b0, -256};
        vecs[2] = '{4'b0000, 1'b0, -128, 1'b0,    0};
        vecs[3] = '{4'b1111, 1'b0,  127, 1'b0,  508};
        vecs[4] = '{4'b1001, 1'b0,  127, 1'b0,  254};
        vecs[5] = '{4'b0110, 1'b0,   -1, 1'b0,   -2};
        vecs[6] = '{4'b1111, 1'b1,    0, 1'b1,    0};
        vecs[7] = '{4'b1011, 1'b1,    0, 1'b1,    0};

        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_raw_addr",  int'(raw_addr), 0);
        chk("rst_rom_en",    int'(rom_en), 0);
        chk("rst_mix",       int'(mix), 0);
        chk("rst_mix_valid", int'(mix_valid), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_ovr",       int'(ovr), 0);
        rst = 1'b0;
        @(negedge clk);

        // Phase steps by 1024 -> addresses 0, 1, 2.
        rom_k = 5;
        write_inc(0, 21'd1024);
        for (int t = 0; t < 3; t++) begin
            tick_sample(4'b0001, 1'b0, 5);
            if (t == 0) chk("busy_in_run", int'(busy), 1);
            wait_idle();
        end

        // Disabled voice zeroes its phase; then half-range steps wrap.
        tick_sample(4'b0000, 1'b0, 0);
        wait_idle();
        write_inc(0, 21'h100000);
        for (int t = 0; t < 3; t++) begin
            tick_sample(4'b0001, 1'b0, 5);
            wait_idle();
        end

        write_inc(1, 21'd3000);
        write_inc(2, 21'd77777);
        write_inc(3, 21'h1FFFFF);
        for (int i = 0; i < 8; i++) begin
            rom_addr_mode = vecs[i].addr_mode;
            rom_k         = vecs[i].k;
            tick_sample(vecs[i].en, vecs[i].use_model, vecs[i].exp_mix);
            wait_idle();
        end

        // Increment written during voice 0's RUN cycle: old step used first.
        rom_addr_mode = 1'b1;
        tick_sample(4'b1111, 1'b1, 0);
        write_inc(0, 21'd2048);
        wait_idle();
        tick_sample(4'b1111, 1'b1, 0);
        wait_idle();

        // Overrun: second tick two cycles later is dropped and sets ovr.
        tick_sample(4'b0011, 1'b1, 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        chk("ovr_set", int'(ovr), 1);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("ovr_sticky", int'(ovr), 1);

        // Set wins over clear in the same cycle.
        tick_sample(4'b0011, 1'b1, 0);
        sample_tick = 1'b1; clr_ovr = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0; clr_ovr = 1'b0;
        @(negedge clk);
        chk("ovr_set_wins", int'(ovr), 1);
        wait_idle();
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", int'(ovr), 0);

        // Reset in RUN cycle 2 aborts the sample.
        rom_addr_mode = 1'b0;
        rom_k = -100;
        tick_sample(4'b1111, 1'b0, -400);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        addr_q.delete();
        mix_q.delete();
        model_reset();
        @(negedge clk);
        chk("arst_raw_addr",  int'(raw_addr), 0);
        chk("arst_rom_en",    int'(rom_en), 0);
        chk("arst_mix",       int'(mix), 0);
        chk("arst_mix_valid", int'(mix_valid), 0);
        chk("arst_busy",      int'(busy), 0);
        chk("arst_ovr",       int'(ovr), 0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        write_inc(0, 21'd1024);
        write_inc(2, 21'd4096);
        rom_addr_mode = 1'b1;
        for (int t = 0; t < 2; t++) begin
            tick_sample(4'b0101, 1'b1, 0);
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/voice_sched.md
VOICE_SCHED -- requirements
Module: voice_sched

Interface
REQ-001 Parameter NV, default 4: number of voices time-sharing one addr_deal and sine ROM path.
REQ-002 Parameter PW, default 21: phase accumulator width; ROM raw address is phase[20:10].
REQ-003 Parameter DW, default 8: signed ROM sample width.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 sample_tick  input  1  one-cycle pulse requesting one mixed output sample.
REQ-007 voice_en  input  NV  per-voice enable.
REQ-008 inc_wr  input  1  phase-increment write strobe.
REQ-009 inc_sel  input  2  voice index for inc_wr.
REQ-010 inc_data  input  PW  phase increment written on inc_wr.
REQ-011 raw_addr  output  11  registered address to addr_deal.
REQ-012 rom_en  output  1  ROM read enable; high only while issuing addresses.
REQ-013 rom_data  input  DW  signed ROM sample; valid one cycle after the address cycle (synchronous ROM).
REQ-014 mix  output  DW+2  signed sum of enabled voice samples.
REQ-015 mix_valid  output  1  one-cycle pulse when mix updates.
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 ovr  output  1  sticky overrun flag.
REQ-018 clr_ovr  input  1  clears ovr.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN; IDLE->RUN on sample_tick with vidx=0 and accumulator cleared; RUN lasts NV cycles (vidx 0..NV-1); RUN->DRAIN after vidx=NV-1; DRAIN->IDLE after one cycle.
REQ-020 RUN cycle k: raw_addr = phase[k][20:10] (pre-update value); rom_en=1; phase[k] <= phase[k]+inc[k] mod 2^PW if voice_en[k], else phase[k] <= 0.
REQ-021 Cycle k+1 (RUN or DRAIN): accumulator += sign-extended rom_data if voice_en[k] was set in cycle k, else += 0.
REQ-022 At the edge ending DRAIN: mix <= accumulator total, mix_valid pulses high the following cycle for exactly one cycle; mix_valid is first high in the 6th cycle after the edge sampling sample_tick (NV=4).
REQ-023 Mix range: NV*(-2^(DW-1)) .. NV*(2^(DW-1)-1); DW+2 bits, no saturation needed.
REQ-024 raw_addr holds its last value in IDLE and DRAIN; rom_en=0 outside RUN.
REQ-025 sample_tick while busy: ignored, ovr set; no second mix_valid.
REQ-026 clr_ovr and new overrun in same cycle: set wins.
REQ-027 inc_wr writes inc[inc_sel] immediately in any state; a voice updated in the same cycle uses the old increment.
REQ-028 Phase wraps modulo 2^PW silently.

Reset
REQ-029 On rst: state IDLE, all phases and increments 0, raw_addr 0, rom_en 0, mix 0, mix_valid 0, busy 0, ovr 0, accumulator 0.
REQ-030 rst mid-RUN/DRAIN aborts the sample; no mix_valid pulse is produced for it.

Structure
REQ-031 Shared package voice_pkg holds the FSM state encoding and the NV/PW/DW constants.
REQ-032 One sub-module phase_bank holds the NV phase and increment registers plus the adders; voice_sched holds FSM, address mux, and mixer.

Verification
REQ-033 inc[0]=1024, voice_en=0001, three ticks -> raw_addr in RUN cycle 0 = 0, 1, 2.
REQ-034 inc[0]=21'h100000, voice_en=0001, three ticks -> raw_addr 0, 1024, 0 (wrap).
REQ-035 ROM model returns -128 for all addresses, voice_en=1111, tick -> mix=-512 with mix_valid 6 cycles after tick; voice_en=0101 -> mix=-256.
REQ-036 Second tick 2 cycles after first -> ovr=1, single mix_valid; clr_ovr -> ovr=0.
REQ-037 rst asserted in RUN cycle 2 -> all outputs 0 next cycle, no mix_valid; next tick after release produces a correct sample starting from phase 0.
